// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter: requester IDs, sequencer states and a grant decoder.
package mem_arbiter_pkg;

  localparam int NUM_REQ = 3;

  typedef enum logic [1:0] {
    REQ_LOADER = 2'd0,
    REQ_CPU    = 2'd1,
    REQ_DEBUG  = 2'd2,
    REQ_NONE   = 2'd3
  } req_id_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } arb_state_e;

  function automatic logic [NUM_REQ-1:0] id_onehot(input req_id_e id);
    logic [NUM_REQ-1:0] oh;
    case (id)
      REQ_LOADER: oh = 3'b001;
      REQ_CPU:    oh = 3'b010;
      REQ_DEBUG:  oh = 3'b100;
      default:    oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester, status and memory-port bundle of mem_arbiter.
// master = arbiter side, slave = requesters plus memory.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 8
);
  logic [2:0]          req_valid;
  logic [2:0]          req_we;
  logic [3*ADDR_W-1:0] req_addr;
  logic [3*DATA_W-1:0] req_wdata;
  logic [2:0]          rsp_ready;
  logic [DATA_W-1:0]   rsp_rdata;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic                mem_read_en;
  logic                mem_write_en;
  logic [DATA_W-1:0]   mem_rdata;
  logic                mem_ready;
  logic [1:0]          grant_id;
  logic                busy;
  logic                err;

  modport master (
    input  req_valid, req_we, req_addr, req_wdata, mem_rdata, mem_ready,
    output rsp_ready, rsp_rdata, mem_addr, mem_wdata, mem_read_en, mem_write_en,
           grant_id, busy, err
  );

  modport slave (
    output req_valid, req_we, req_addr, req_wdata, mem_rdata, mem_ready,
    input  rsp_ready, rsp_rdata, mem_addr, mem_wdata, mem_read_en, mem_write_en,
           grant_id, busy, err
  );
endinterface

// File: rtl/mem_arb_prio.sv
// Boot-phase eligibility and fixed priority (debug > loader > cpu) for mem_arbiter.
module mem_arb_prio
  import mem_arbiter_pkg::*;
(
  input  logic [2:0] req_valid,
  input  logic       boot_done,
  input  logic       halt,
  output req_id_e    winner,
  output logic       hit
);
  logic [2:0] elig_s;

  // Mask requests by phase, then pick the highest-priority survivor
  always_comb begin
    elig_s = req_valid & {1'b1, boot_done & ~halt, ~boot_done};
    winner = REQ_NONE;
    hit    = 1'b0;
    if (elig_s[2]) begin
      winner = REQ_DEBUG;
      hit    = 1'b1;
    end else if (elig_s[0]) begin
      winner = REQ_LOADER;
      hit    = 1'b1;
    end else if (elig_s[1]) begin
      winner = REQ_CPU;
      hit    = 1'b1;
    end else begin
      winner = REQ_NONE;
      hit    = 1'b0;
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// Shares one byte-wide memory port between loader, cpu and debug requesters.
// Optional ISSUE watchdog with sticky err: define MEM_ARB_TIMEOUT_EN.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          boot_done,
  input  logic          halt,
  mem_arbiter_if.master bus
);
  arb_state_e        state_r;
  req_id_e           grant_r;
  req_id_e           winner_s;
  logic              hit_s;
  logic              busy_r;
  logic              we_r;
  logic              read_en_r;
  logic              write_en_r;
  logic [2:0]        rsp_ready_r;
  logic [DATA_W-1:0] rsp_rdata_r;
  logic [DATA_W-1:0] wdata_r;
  logic [ADDR_W-1:0] addr_r;
  logic              wd_expire_s;

  mem_arb_prio u_prio (
    .req_valid (bus.req_valid),
    .boot_done (boot_done),
    .halt      (halt),
    .winner    (winner_s),
    .hit       (hit_s)
  );

`ifdef MEM_ARB_TIMEOUT_EN
  logic [15:0] wd_cnt_r;
  logic        err_r;

  assign wd_expire_s = (wd_cnt_r == 16'(TIMEOUT_CYCLES - 1));
  assign bus.err     = err_r;

  // Watchdog: counts stalled ISSUE cycles; err stays set until rst
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt_r <= 16'd0;
      err_r    <= 1'b0;
    end else if (state_r == IDLE) begin
      wd_cnt_r <= 16'd0;
    end else if ((state_r == ISSUE) && !bus.mem_ready) begin
      if (wd_expire_s) begin
        err_r <= 1'b1;
      end else begin
        wd_cnt_r <= wd_cnt_r + 16'd1;
      end
    end
  end
`else
  assign wd_expire_s = 1'b0;
  assign bus.err     = 1'b0;
`endif

  // Transaction sequencer: arbitrate in IDLE, hold the access in ISSUE, respond in GAP
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      grant_r     <= REQ_NONE;
      busy_r      <= 1'b0;
      we_r        <= 1'b0;
      read_en_r   <= 1'b0;
      write_en_r  <= 1'b0;
      rsp_ready_r <= 3'b000;
      rsp_rdata_r <= '0;
      wdata_r     <= '0;
      addr_r      <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (hit_s) begin
            grant_r    <= winner_s;
            we_r       <= bus.req_we[winner_s];
            addr_r     <= bus.req_addr[ADDR_W*int'(winner_s) +: ADDR_W];
            wdata_r    <= bus.req_wdata[DATA_W*int'(winner_s) +: DATA_W];
            read_en_r  <= ~bus.req_we[winner_s];
            write_en_r <= bus.req_we[winner_s];
            busy_r     <= 1'b1;
            state_r    <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.mem_ready) begin
            read_en_r   <= 1'b0;
            write_en_r  <= 1'b0;
            rsp_ready_r <= id_onehot(grant_r);
            if (!we_r) begin
              rsp_rdata_r <= bus.mem_rdata;
            end
            state_r <= GAP;
          end else if (wd_expire_s) begin
            read_en_r   <= 1'b0;
            write_en_r  <= 1'b0;
            rsp_ready_r <= id_onehot(grant_r);
            rsp_rdata_r <= {DATA_W{1'b1}};
            state_r     <= GAP;
          end
        end
        GAP: begin
          rsp_ready_r <= 3'b000;
          grant_r     <= REQ_NONE;
          busy_r      <= 1'b0;
          state_r     <= IDLE;
        end
        default: begin
          read_en_r   <= 1'b0;
          write_en_r  <= 1'b0;
          rsp_ready_r <= 3'b000;
          grant_r     <= REQ_NONE;
          busy_r      <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign bus.grant_id     = grant_r;
  assign bus.busy         = busy_r;
  assign bus.mem_read_en  = read_en_r;
  assign bus.mem_write_en = write_en_r;
  assign bus.mem_addr     = addr_r;
  assign bus.mem_wdata    = wdata_r;
  assign bus.rsp_ready    = rsp_ready_r;
  assign bus.rsp_rdata    = rsp_rdata_r;
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a transaction-level model plus directed pins.
module tb_mem_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 8;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TO = 8;
  localparam bit TO_EN = 1'b1;
`else
  localparam int TO = 64;
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, boot_done, halt;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .boot_done(boot_done), .halt(halt), .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;
  int cyc = 0;

  logic [7:0] mem_arr [0:4095];
  logic [7:0] shadow  [0:4095];
  int  fix_lat = -1;
  bit  mem_hold = 1'b0;
  bit  noise = 1'b0;
  bit  in_acc = 1'b0;
  int  lat_left = 0;

  int rsp_seen [3];
  int last_rsp_cyc [3];
  int wr_cyc, rd_cyc, en_low, busy_grant;

  // transaction-level reference model
  bit         m_act, m_fin, m_we, m_err;
  int         m_id, m_age;
  logic [31:0] m_addr;
  logic [7:0] m_wdata, m_rdata;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [2:0] v, input logic bd, input logic h);
    int order [3];
    bit elig [3];
    order[0] = 2; order[1] = 0; order[2] = 1;
    elig[0] = !bd; elig[1] = bd && !h; elig[2] = 1'b1;
    for (int k = 0; k < 3; k++)
      if (v[order[k]] && elig[order[k]]) return order[k];
    return 3;
  endfunction

  // Advance the model by what the DUT saw on the edge just passed
  task automatic model_tick();
    int w;
    if (rst) begin
      m_act = 0; m_fin = 0; m_id = 3; m_we = 0; m_addr = '0; m_wdata = '0;
      m_rdata = '0; m_err = 0; m_age = 0;
    end else if (m_act && m_fin) begin
      m_act = 0; m_id = 3;
    end else if (m_act) begin
      m_age++;
      if (bus.mem_ready) begin
        m_fin = 1;
        if (m_we) shadow[m_addr[11:0]] = m_wdata;
        else m_rdata = shadow[m_addr[11:0]];
      end else if (TO_EN && m_age == TO) begin
        m_fin = 1; m_rdata = 8'hFF; m_err = 1;
      end
    end else begin
      w = pick(bus.req_valid, boot_done, halt);
      if (w != 3) begin
        m_act = 1; m_fin = 0; m_id = w; m_age = 0;
        m_we = bus.req_we[w];
        m_addr = bus.req_addr[w*ADDR_W +: ADDR_W];
        m_wdata = bus.req_wdata[w*DATA_W +: DATA_W];
      end
    end
  endtask

  task automatic compare();
    bit en;
    en = m_act && !m_fin;
    chk("grant_id", bus.grant_id, m_act ? m_id : 3);
    chk("busy", bus.busy, m_act);
    chk("mem_read_en", bus.mem_read_en, en && !m_we);
    chk("mem_write_en", bus.mem_write_en, en && m_we);
    chk("rsp_ready", bus.rsp_ready, (m_act && m_fin) ? 3'(1 << m_id) : 3'b000);
    chk("rsp_rdata", bus.rsp_rdata, m_rdata);
    chk("err", bus.err, m_err);
    chk("mem_addr", bus.mem_addr, m_addr);
    chk("mem_wdata", bus.mem_wdata, m_wdata);
  endtask

  task automatic mem_drive();
    if (bus.mem_read_en === 1'b1 || bus.mem_write_en === 1'b1) begin
      if (!in_acc) begin
        in_acc = 1;
        lat_left = (fix_lat >= 0) ? fix_lat : int'($urandom_range(0, 3));
      end
      if (!mem_hold && lat_left == 0) begin
        bus.mem_ready = 1'b1;
        if (bus.mem_write_en) mem_arr[bus.mem_addr[11:0]] = bus.mem_wdata;
        else bus.mem_rdata = mem_arr[bus.mem_addr[11:0]];
      end else begin
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 8'($urandom);
        if (lat_left > 0) lat_left--;
      end
    end else begin
      in_acc = 0;
      bus.mem_ready = noise && ($urandom_range(0, 7) == 0);
      bus.mem_rdata = 8'($urandom);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    model_tick();
    if (cmp_on) compare();
    if (bus.mem_write_en === 1'b1) wr_cyc++;
    if (bus.mem_read_en === 1'b1) rd_cyc++;
    if (bus.mem_read_en === 1'b0 && bus.mem_write_en === 1'b0 && bus.rsp_ready === 3'b000) en_low++;
    if (bus.busy === 1'b1) busy_grant = int'(bus.grant_id);
    for (int i = 0; i < 3; i++)
      if (bus.rsp_ready[i] === 1'b1) begin
        bus.req_valid[i] = 1'b0;
        rsp_seen[i]++;
        last_rsp_cyc[i] = cyc;
      end
    mem_drive();
  endtask

  task automatic raise(input int id, input bit we, input logic [31:0] a, input logic [7:0] d);
    bus.req_we[id] = we;
    bus.req_addr[id*ADDR_W +: ADDR_W] = a;
    bus.req_wdata[id*DATA_W +: DATA_W] = d;
    bus.req_valid[id] = 1'b1;
  endtask

  task automatic wait_rsp(input int id, input int budget);
    int start, n;
    start = rsp_seen[id];
    n = 0;
    while (rsp_seen[id] == start && n < budget) begin
      step();
      n++;
    end
    chk($sformatf("wait_rsp%0d", id), rsp_seen[id] - start, 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy !== 1'b0 && n < 200) begin
      step();
      n++;
    end
    step();
  endtask

  initial begin
    int c0, c1, s0;
    logic [7:0] v;
    for (int i = 0; i < 4096; i++) begin
      v = 8'($urandom);
      mem_arr[i] = v;
      shadow[i] = v;
    end
    mem_arr[12'h010] = 8'h5A; shadow[12'h010] = 8'h5A;
    mem_arr[12'h011] = 8'hC3; shadow[12'h011] = 8'hC3;
    for (int i = 0; i < 3; i++) begin rsp_seen[i] = 0; last_rsp_cyc[i] = 0; end
    rst = 1'b1; boot_done = 1'b0; halt = 1'b0;
    bus.req_valid = 3'b000; bus.req_we = 3'b000; bus.req_addr = '0; bus.req_wdata = '0;
    bus.mem_ready = 1'b0; bus.mem_rdata = 8'h00;
    step(); step();
    // reset values
    chk("rst_grant", bus.grant_id, 2'b11);
    chk("rst_en", {bus.mem_read_en, bus.mem_write_en}, 2'b00);
    chk("rst_rsp", bus.rsp_ready, 3'b000);
    chk("rst_rdata", bus.rsp_rdata, 8'h00);
    chk("rst_err", bus.err, 1'b0);
    chk("rst_addr", bus.mem_addr, 32'h0);
    rst = 1'b0;
    cmp_on = 1'b1;

    // boot: loader write, then debug read back
    fix_lat = 1; wr_cyc = 0; s0 = rsp_seen[0];
    raise(0, 1'b1, 32'h604, 8'h08);
    wait_rsp(0, 50);
    chk("boot_wr_cycles", wr_cyc, 2);
    for (int i = 0; i < 5; i++) step();
    chk("boot_rsp_once", rsp_seen[0] - s0, 1);
    raise(2, 1'b0, 32'h604, 8'h00);
    wait_rsp(2, 50);
    chk("boot_readback", bus.rsp_rdata, 8'h08);
    wait_idle();

    // phase gating: loader ignored once boot_done is set
    boot_done = 1'b1; s0 = rsp_seen[0];
    raise(0, 1'b1, 32'h700, 8'h11);
    raise(1, 1'b0, 32'h20, 8'h00);
    wait_rsp(1, 50);
    chk("gate_grant", busy_grant, 1);
    for (int i = 0; i < 10; i++) step();
    chk("gate_no_loader", rsp_seen[0] - s0, 0);
    bus.req_valid[0] = 1'b0;
    wait_idle();

    // priority: debug beats cpu, cpu follows one slot later
    fix_lat = 2;
    raise(1, 1'b0, 32'h30, 8'h00);
    raise(2, 1'b0, 32'h31, 8'h00);
    wait_rsp(1, 60);
    chk("prio_slot", last_rsp_cyc[1] - last_rsp_cyc[2], 5);
    wait_idle();
    raise(1, 1'b0, 32'h32, 8'h00);
    step(); step();
    raise(2, 1'b0, 32'h33, 8'h00);
    wait_rsp(2, 60);
    chk("nonpreempt_slot", last_rsp_cyc[2] - last_rsp_cyc[1], 5);
    wait_idle();

    // back-to-back cpu reads with an idle gap between them
    fix_lat = 1;
    raise(1, 1'b0, 32'h10, 8'h00);
    wait_rsp(1, 50);
    chk("b2b_rd0", bus.rsp_rdata, 8'h5A);
    c0 = last_rsp_cyc[1]; en_low = 0;
    raise(1, 1'b0, 32'h11, 8'h00);
    wait_rsp(1, 50);
    c1 = last_rsp_cyc[1];
    chk("b2b_rd1", bus.rsp_rdata, 8'hC3);
    chk("b2b_period", c1 - c0, 4);
    chk("b2b_gap", en_low >= 1, 1'b1);
    wait_idle();

    // reset in the middle of a write access
    fix_lat = 20; s0 = rsp_seen[1];
    raise(1, 1'b1, 32'h40, 8'h77);
    for (int n = 0; n < 20 && bus.mem_write_en !== 1'b1; n++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstmid_en", {bus.mem_read_en, bus.mem_write_en}, 2'b00);
    chk("rstmid_grant", bus.grant_id, 2'b11);
    chk("rstmid_rsp", rsp_seen[1] - s0, 0);
    fix_lat = 0;
    wait_rsp(1, 50);
    chk("rstmid_retry", mem_arr[12'h040], 8'h77);
    wait_idle();

`ifdef MEM_ARB_TIMEOUT_EN
    mem_hold = 1'b1; rd_cyc = 0;
    raise(1, 1'b0, 32'h50, 8'h00);
    wait_rsp(1, 60);
    chk("to_issue_cycles", rd_cyc, 8);
    chk("to_rdata", bus.rsp_rdata, 8'hFF);
    chk("to_err", bus.err, 1'b1);
    mem_hold = 1'b0;
    raise(1, 1'b0, 32'h10, 8'h00);
    wait_rsp(1, 50);
    chk("to_err_sticky", bus.err, 1'b1);
    wait_idle();
    rst = 1'b1; step(); rst = 1'b0; step();
    chk("to_err_clear", bus.err, 1'b0);
`endif

    // randomized traffic with phase changes and stray mem_ready pulses
    fix_lat = -1; noise = 1'b1; s0 = rsp_seen[0] + rsp_seen[1] + rsp_seen[2];
    for (int n = 0; n < 3000; n++) begin
      step();
      if ($urandom_range(0, 99) == 0) boot_done = ~boot_done;
      if ($urandom_range(0, 49) == 0) halt = ~halt;
      for (int id = 0; id < 3; id++)
        if (!bus.req_valid[id] && $urandom_range(0, 9) == 0)
          raise(id, 1'($urandom), 32'($urandom_range(0, 63)), 8'($urandom));
      if (boot_done && bus.req_valid[0] && bus.grant_id != 2'd0 && $urandom_range(0, 3) == 0)
        bus.req_valid[0] = 1'b0;
      if (halt && bus.req_valid[1] && bus.grant_id != 2'd1 && $urandom_range(0, 7) == 0)
        bus.req_valid[1] = 1'b0;
    end
    chk("random_progress", (rsp_seen[0] + rsp_seen[1] + rsp_seen[2] - s0) > 50, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single byte-wide `memory` port between three requesters: wasm loader (ID 0), cpu (ID 1) and debug/host port (ID 2).
- Replaces the ad-hoc `mem_access` mux.
- Eligibility is gated by boot phase (`boot_done` = `rom_mapped`) and `halt`.
- Each transaction runs req → issue → `mem_ready` → response, with a mandatory idle gap so the memory always sees a fresh request.

Parameters:
- ADDR_W, 32, memory address width
- DATA_W, 8, memory data width
- TIMEOUT_CYCLES, 64, watchdog limit in ISSUE (used only with MEM_ARB_TIMEOUT_EN)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- boot_done  in  1  loader finished; level, from wasm `rom_mapped`
- halt  in  1  cpu execution stopped; debug-only phase
- req_valid  in  3  per-requester request, held until its rsp_ready
- req_we  in  3  per-requester: 1 = write, 0 = read
- req_addr  in  3*ADDR_W  packed addresses; ID n at [n*ADDR_W +: ADDR_W]
- req_wdata  in  3*DATA_W  packed write data
- rsp_ready  out  3  one-cycle completion pulse to the granted ID
- rsp_rdata  out  DATA_W  read data of the last completed read
- mem_addr  out  ADDR_W  to memory
- mem_wdata  out  DATA_W  to memory
- mem_read_en  out  1  to memory
- mem_write_en  out  1  to memory
- mem_rdata  in  DATA_W  from memory
- mem_ready  in  1  memory completion pulse, for reads and writes
- grant_id  out  2  current owner; 2'b11 = none
- busy  out  1  state != IDLE
- err  out  1  sticky timeout flag

Behaviour:
- Reset: state IDLE; mem_addr=0, mem_wdata=0, enables=0, rsp_ready=0, rsp_rdata=0, grant_id=2'b11, err=0. Reset mid-transaction abandons it; no rsp_ready is issued.
- Eligibility:
  - ID 0 only while !boot_done.
  - ID 1 only while boot_done && !halt.
  - ID 2 always.
- Priority among eligible valid requests: fixed, 2 > 0 > 1. Non-preemptive.
- IDLE: if any eligible req_valid, latch that ID's addr/we/wdata, set grant_id, and register the matching enable. Go to ISSUE. Enables are high in the first ISSUE cycle, one cycle after the request is sampled.
- ISSUE: hold mem_addr, mem_wdata and the enable steady until mem_ready is sampled high. On that edge:
  - deassert the enable;
  - pulse rsp_ready[grant_id];
  - if read, capture mem_rdata into rsp_rdata;
  - go to GAP.
- GAP: one cycle. Enables are low and rsp_ready is high. Next edge: rsp_ready=0, grant_id=2'b11, go to IDLE.
- Requester contract: drop req_valid on the edge where rsp_ready is sampled. If req_valid is still high in IDLE, it is a new request.
- Best-case latency: request sampled at t, enable at t+1, mem_ready at t+1+k, rsp_ready visible k+2 cycles after t. Back-to-back throughput is one transaction per k+3 cycles.
- Eligibility changes mid-transaction (boot_done rise, halt rise/fall) never abort the owner. The change applies at the next IDLE.
- Loader requests after boot_done are never granted; no response is issued.
- Simultaneous requests: a loser keeps req_valid high and is re-arbitrated at the next IDLE. Debug can starve cpu; this is accepted.
- rsp_rdata holds its value across writes and idle periods.
- mem_ready outside ISSUE is ignored.

Optional Feature:
- MEM_ARB_TIMEOUT_EN
- Defined:
  - a 16-bit counter clears on entry to ISSUE and increments each ISSUE cycle;
  - when it reaches TIMEOUT_CYCLES without mem_ready, deassert the enables, pulse rsp_ready with rsp_rdata=8'hFF, set err (sticky until rst), go to GAP;
  - mem_ready and timeout on the same edge: mem_ready wins and err is unchanged.
- Undefined: ISSUE waits indefinitely; err is tied 0; no counter is instantiated.

Decomposition:
- Add requester IDs (REQ_LOADER=0, REQ_CPU=1, REQ_DEBUG=2, REQ_NONE=3) and state encodings (IDLE, ISSUE, GAP) to `src/platform.v`, beside OP_STACK_TOP.
- One combinational sub-module, mem_arb_prio. Inputs: req_valid, boot_done, halt. Outputs: winner ID and a hit flag. It is tested standalone.

Test Plan:
- Boot: boot_done=0, loader writes 8'h08 to 32'h604 → mem_write_en high for one access, rsp_ready[0] pulses once. Debug then reads 32'h604 → rsp_rdata=8'h08.
- Phase gating: boot_done=1, loader and cpu both request → only cpu is granted (grant_id=1); rsp_ready[0] never asserts.
- Priority: cpu and debug both request in the same cycle → debug completes first, then cpu one k+3 cycle slot later. Mid-cpu debug request waits for cpu's GAP.
- Gap: cpu performs reads at 32'h10 and 32'h11 back-to-back → at least one cycle with both enables low between them. Each rsp_rdata matches the memory contents.
- Reset mid-ISSUE: assert rst while the enable is high → next cycle enables=0, grant_id=3, no rsp_ready. A request after reset completes normally.
- Timeout, with MEM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8: memory holds mem_ready low → rsp_ready after 8 ISSUE cycles, rsp_rdata=8'hFF, err=1 until rst.
